imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, flow-controlled immediate generator. Successor to the combinational immediate decoder.
- Generalised to XLEN 32/64. Adds CSR-zimm and shift-amount formats, an illegal-format flag, and a 2-entry skid buffer with valid/ready on both sides.
- Sits between the decode and execute stages. Carries an opaque tag, for example the ROB or PC index, alongside each immediate.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; out_imm is sign-extended to XLEN.
- TAG_W, 8, width of the side-band tag carried with each entry.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; equals (state != FULL).
- in_inst  in  32  raw instruction word.
- in_imm_type  in  3  format select (encoding below).
- in_tag  in  TAG_W  side-band tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_imm  out  XLEN  generated immediate.
- out_tag  out  TAG_W  tag of head entry.
- out_err  out  1  head entry had an illegal format.

Behaviour:
- Reset: asynchronous on rst_n low. Reset values: state=EMPTY, out_valid=0, out_imm=0, out_tag=0, out_err=0, in_ready=1. Inputs are ignored while rst_n is low. Reset mid-operation drops all entries immediately; out_valid falls without waiting for a clock edge.
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready. in_valid may not depend on in_ready. Outputs are stable while out_valid=1 and out_ready=0.
- Latency: an entry accepted at edge N into EMPTY is presented at out_* after edge N (1 cycle).
- States: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE, new entry becomes head.
  - FULL: in_ready=0; pop -> ONE, second entry becomes head.
- Ordering: strict FIFO order is kept.
- Storage: immediates are computed combinationally at push time and stored, not recomputed at the output.
- Type encoding (in_imm_type):
  - 0 I: sext(inst[31:20]).
  - 1 S: sext({inst[31:25], inst[11:7]}).
  - 2 B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 3 U: sext({inst[31:12], 12'b0}); for XLEN=64, bits 63:32 = inst[31].
  - 4 J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 5 Z: zext(inst[19:15]).
  - 6 SH: zext(inst[24:20]) if XLEN=32; zext(inst[25:20]) if XLEN=64.
  - 7: illegal; imm=0, err=1. err=0 for all other types.
- Sign extension always replicates the format's top bit up to bit XLEN-1.

Optional Feature:
- Macro: IMM_GEN_RVC_EN.
- Defined:
  - Adds input port in_rvc (1 bit, between in_imm_type and in_tag).
  - When in_rvc=1, in_inst[15:0] is decoded and in_imm_type selects a compressed format:
    - 0 CI: sext({i[12], i[6:2]}).
    - 1 CIW: zext({i[10:7], i[12:11], i[5], i[6], 2'b0}).
    - 2 CB: sext({i[12], i[6:5], i[2], i[11:10], i[4:3], 0}).
    - 3 CJ: sext({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 0}).
    - 4 CLW: zext({i[5], i[12:10], i[6], 2'b0}).
    - 5-7: illegal; imm=0, err=1.
- Undefined: port in_rvc is absent; only the 32-bit formats exist.

Decomposition:
- Package imm_pkg holds:
  - imm_type_e enum (IMM_I..IMM_ILL) and rvc_type_e enum.
  - state enum (EMPTY/ONE/FULL).
  - Constant IMM_TYPE_W=3.
- One combinational sub-module, imm_extract, parametrised by XLEN: (inst, type, rvc) -> (imm, err).
- imm_gen_pipe instantiates imm_extract once on the input side and implements the skid buffer and FSM.

Test Plan:
- XLEN=32, type I, inst 0xFFF00093, out_ready=1 -> out_imm 0xFFFFFFFF, out_err=0, out_valid exactly 1 cycle after accept.
- Type B, inst 0xFE000EE3 -> 0xFFFFFFFC. Type J, inst 0x0000006F -> 0x00000000.
- XLEN=64, type U, inst 0x800000B7 -> 0xFFFFFFFF80000000. Type SH, inst[25:20]=0x3F -> 0x3F; same inst at XLEN=32 -> 0x1F.
- out_ready=0, drive 3 pushes with tags 1,2,3:
  - Only tags 1,2 are accepted; in_ready=0 while FULL.
  - Then out_ready=1: outputs tag 1, 2, then 3 in order, no loss or duplication.
  - Simultaneous push and pop in ONE holds ONE.
- Type 7, any inst -> out_imm 0, out_err=1; the following legal entry has out_err=0.
- Fill to FULL, then pulse rst_n low mid-cycle -> out_valid=0 and in_ready=1 before the next clock edge; no stale entry after release.
- With IMM_GEN_RVC_EN: in_rvc=1, type CI, inst 0x1FFD (c.addi x31,-1) -> 0xFFFFFFFF.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and constants for the registered immediate generator.
package imm_pkg;

  localparam int unsigned IMM_TYPE_W = 3;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_ILL = 3'd7
  } imm_type_e;

  // Compressed formats; encodings 5-7 are illegal.
  typedef enum logic [IMM_TYPE_W-1:0] {
    RVC_CI  = 3'd0,
    RVC_CIW = 3'd1,
    RVC_CB  = 3'd2,
    RVC_CJ  = 3'd3,
    RVC_CLW = 3'd4
  } rvc_type_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for all formats; IMM_GEN_RVC_EN enables compressed decode.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]           inst,
  input  logic [IMM_TYPE_W-1:0] imm_type,
  input  logic                  rvc,
  output logic [XLEN-1:0]       imm,
  output logic                  err
);

  logic [31:0] v;
  logic [63:0] v64;
  logic        unused_inst;

  always_comb begin
    v   = '0;
    err = 1'b0;
`ifdef IMM_GEN_RVC_EN
    if (rvc) begin
      case (rvc_type_e'(imm_type))
        RVC_CI:  v = {{26{inst[12]}}, inst[12], inst[6:2]};
        RVC_CIW: v = {22'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
        RVC_CB:  v = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
        RVC_CJ:  v = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2],
                      inst[11], inst[5:3], 1'b0};
        RVC_CLW: v = {25'b0, inst[5], inst[12:10], inst[6], 2'b00};
        default: err = 1'b1;
      endcase
    end else
`endif
    begin
      unique case (imm_type_e'(imm_type))
        IMM_I:   v = {{20{inst[31]}}, inst[31:20]};
        IMM_S:   v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        IMM_B:   v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        IMM_U:   v = {inst[31:12], 12'b0};
        IMM_J:   v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        IMM_Z:   v = {27'b0, inst[19:15]};
        IMM_SH: begin
          if (XLEN == 64) v = {26'b0, inst[25:20]};
          else            v = {27'b0, inst[24:20]};
        end
        IMM_ILL: err = 1'b1;
        default: err = 1'b1;
      endcase
    end
  end

  // Every format is formed at 32 bits with its sign at bit 31, so one extension serves all.
  assign v64 = sext32(v);
  assign imm = v64[XLEN-1:0];

  assign unused_inst = ^{inst[6:0], rvc};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and valid/ready on both sides.
// Optional compressed decode (in_rvc port) is enabled by defining IMM_GEN_RVC_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [IMM_TYPE_W-1:0] in_imm_type,
`ifdef IMM_GEN_RVC_EN
  input  logic                  in_rvc,
`endif
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  logic            rvc;
  logic [XLEN-1:0] new_imm;
  logic            new_err;

`ifdef IMM_GEN_RVC_EN
  assign rvc = in_rvc;
`else
  assign rvc = 1'b0;
`endif

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst    (in_inst),
    .imm_type(in_imm_type),
    .rvc     (rvc),
    .imm     (new_imm),
    .err     (new_err)
  );

  state_e           state_q, state_d;
  logic [XLEN-1:0]  head_imm_q, skid_imm_q;
  logic [TAG_W-1:0] head_tag_q, skid_tag_q;
  logic             head_err_q, skid_err_q;
  logic             push, pop;
  logic             head_load_new, head_load_skid, skid_load;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    head_load_new  = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d       = ONE;
          head_load_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_load_new = 1'b1;
        end else if (push) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          head_load_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_imm   = head_imm_q;
    out_tag   = head_tag_q;
    out_err   = head_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_imm_q <= '0;
      head_tag_q <= '0;
      head_err_q <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (head_load_new) begin
        head_imm_q <= new_imm;
        head_tag_q <= in_tag;
        head_err_q <= new_err;
      end else if (head_load_skid) begin
        head_imm_q <= skid_imm_q;
        head_tag_q <= skid_tag_q;
        head_err_q <= skid_err_q;
      end
      if (skid_load) begin
        skid_imm_q <= new_imm;
        skid_tag_q <= in_tag;
        skid_err_q <= new_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe; drives an XLEN=32 and an XLEN=64 instance in lockstep.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_type;
  logic [7:0]  in_tag;
  logic        out_ready;
`ifdef IMM_GEN_RVC_EN
  logic        in_rvc;
`endif

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready32),
    .in_inst    (in_inst),
    .in_imm_type(in_imm_type),
`ifdef IMM_GEN_RVC_EN
    .in_rvc     (in_rvc),
`endif
    .in_tag     (in_tag),
    .out_valid  (out_valid32),
    .out_ready  (out_ready),
    .out_imm    (out_imm32),
    .out_tag    (out_tag32),
    .out_err    (out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready64),
    .in_inst    (in_inst),
    .in_imm_type(in_imm_type),
`ifdef IMM_GEN_RVC_EN
    .in_rvc     (in_rvc),
`endif
    .in_tag     (in_tag),
    .out_valid  (out_valid64),
    .out_ready  (out_ready),
    .out_imm    (out_imm64),
    .out_tag    (out_tag64),
    .out_err    (out_err64)
  );

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    in_imm_type = 3'd0;
    in_tag    = 8'hAA;
    out_ready = 1'b0;
`ifdef IMM_GEN_RVC_EN
    in_rvc    = 1'b0;
`endif
    #2;
    check_cnt++;
    if ({out_valid32, out_valid64, in_ready32, in_ready64} !== 4'b0011)
      $display("FAIL reset_flags: got %b want 0011",
               {out_valid32, out_valid64, in_ready32, in_ready64});
    else pass_cnt++;
    // Inputs are active across an edge but must be ignored while in reset.
    @(posedge clk); #1;
    check_cnt++;
    if ({out_imm32, out_imm64, out_tag32, out_err32, out_valid32} !== '0)
      $display("FAIL reset_values: imm32=%h imm64=%h tag=%h err=%b valid=%b",
               out_imm32, out_imm64, out_tag32, out_err32, out_valid32);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_formats();
    logic [31:0] vi   [10];
    logic [2:0]  vt   [10];
    logic [31:0] e32  [10];
    logic [63:0] e64  [10];
    logic        eerr [10];
    vi[0] = 32'hFFF00093; vt[0] = 3'd0; e32[0] = 32'hFFFFFFFF; e64[0] = 64'hFFFFFFFFFFFFFFFF;
    vi[1] = 32'h00A12423; vt[1] = 3'd1; e32[1] = 32'h00000008; e64[1] = 64'h8;
    vi[2] = 32'hFE000EE3; vt[2] = 3'd2; e32[2] = 32'hFFFFFFFC; e64[2] = 64'hFFFFFFFFFFFFFFFC;
    vi[3] = 32'h800000B7; vt[3] = 3'd3; e32[3] = 32'h80000000; e64[3] = 64'hFFFFFFFF80000000;
    vi[4] = 32'h0000006F; vt[4] = 3'd4; e32[4] = 32'h00000000; e64[4] = 64'h0;
    vi[5] = 32'hFFDFF06F; vt[5] = 3'd4; e32[5] = 32'hFFFFFFFC; e64[5] = 64'hFFFFFFFFFFFFFFFC;
    vi[6] = 32'h000F8000; vt[6] = 3'd5; e32[6] = 32'h0000001F; e64[6] = 64'h1F;
    vi[7] = 32'h03F00013; vt[7] = 3'd6; e32[7] = 32'h0000001F; e64[7] = 64'h3F;
    vi[8] = 32'hFFFFFFFF; vt[8] = 3'd7; e32[8] = 32'h00000000; e64[8] = 64'h0;
    vi[9] = 32'h00100093; vt[9] = 3'd0; e32[9] = 32'h00000001; e64[9] = 64'h1;
    for (int i = 0; i < 10; i++) eerr[i] = (i == 8);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_inst     = vi[i];
      in_imm_type = vt[i];
      in_tag      = 8'h10 + 8'(i);
      check_cnt++;
      if (out_valid32 !== 1'b0)
        $display("FAIL fmt%0d_pre_valid: got %b want 0", i, out_valid32);
      else pass_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_cnt++;
      if ({out_valid32, out_valid64} !== 2'b11)
        $display("FAIL fmt%0d_latency: valid32=%b valid64=%b want 1", i, out_valid32, out_valid64);
      else pass_cnt++;
      check_cnt++;
      if (out_imm32 !== e32[i] || out_imm64 !== e64[i])
        $display("FAIL fmt%0d_imm: got %h/%h want %h/%h", i, out_imm32, out_imm64, e32[i], e64[i]);
      else pass_cnt++;
      check_cnt++;
      if (out_err32 !== eerr[i] || out_err64 !== eerr[i] || out_tag32 !== 8'h10 + 8'(i))
        $display("FAIL fmt%0d_err_tag: err=%b/%b tag=%h want err=%b tag=%h", i, out_err32,
                 out_err64, out_tag32, eerr[i], 8'h10 + 8'(i));
      else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++;
      if (out_valid32 !== 1'b0)
        $display("FAIL fmt%0d_drain: valid=%b want 0", i, out_valid32);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_imm_type = 3'd0;
      in_inst     = {12'(t), 20'h00093};
      in_tag      = 8'(t);
      check_cnt++;
      if (in_ready32 !== (t < 3))
        $display("FAIL bp_in_ready_%0d: got %b want %b", t, in_ready32, (t < 3));
      else pass_cnt++;
      @(posedge clk);
    end
    @(negedge clk);
    // Still FULL with tag 1 at the head; tag 3 is held on the input.
    check_cnt++;
    if (out_tag32 !== 8'd1 || in_ready32 !== 1'b0 || out_valid32 !== 1'b1)
      $display("FAIL bp_full_hold: tag=%0d in_ready=%b valid=%b want 1/0/1",
               out_tag32, in_ready32, out_valid32);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_cnt++;
    if (out_tag32 !== 8'd2 || out_imm32 !== 32'd2 || in_ready32 !== 1'b1)
      $display("FAIL bp_second: tag=%0d imm=%0d in_ready=%b want 2/2/1",
               out_tag32, out_imm32, in_ready32);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if (out_tag32 !== 8'd3 || out_imm64 !== 64'd3 || out_valid32 !== 1'b1 || in_ready32 !== 1'b1)
      $display("FAIL bp_push_pop_one: tag=%0d imm=%0d valid=%b in_ready=%b want 3/3/1/1",
               out_tag32, out_imm64, out_valid32, in_ready32);
    else pass_cnt++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_cnt++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0)
      $display("FAIL bp_empty: valid=%b/%b want 0", out_valid32, out_valid64);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_imm_type = 3'd1;
      in_inst     = 32'hFE000FA3;
      in_tag      = 8'h40 + 8'(t);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_cnt++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1)
      $display("FAIL mid_full: in_ready=%b valid=%b want 0/1", in_ready32, out_valid32);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || out_tag32 !== 8'h0)
      $display("FAIL mid_async: valid=%b/%b in_ready=%b tag=%h want 0/0/1/00",
               out_valid32, out_valid64, in_ready32, out_tag32);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_cnt++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1)
      $display("FAIL mid_no_stale: valid=%b in_ready=%b want 0/1", out_valid32, in_ready32);
    else pass_cnt++;
  endtask

`ifdef IMM_GEN_RVC_EN
  task automatic test_rvc();
    @(negedge clk);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_rvc      = 1'b1;
    in_imm_type = 3'd0;
    in_inst     = 32'h00001FFD;
    in_tag      = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_rvc   = 1'b0;
    check_cnt++;
    if (out_imm32 !== 32'hFFFFFFFF || out_imm64 !== 64'hFFFFFFFFFFFFFFFF || out_err32 !== 1'b0)
      $display("FAIL rvc_ci: got %h/%h err=%b want all-ones err=0", out_imm32, out_imm64, out_err32);
    else pass_cnt++;
    @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_reset_mid();
`ifdef IMM_GEN_RVC_EN
    test_rvc();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
